// File: rtl/bitty_fetch_sequencer.sv
// rtl/bitty_fetch_sequencer.sv - Bitty program sequencer: fetch, issue, run/done handshake, halt and watchdog.
// Optional BITTY_BRANCH_EN: NEXT loads branch_target_i when branch_taken_i is high.
module bitty_fetch_sequencer #(
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] LAST_ADDR    = 8'hFF,
    parameter int                DONE_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              stop_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_req_o,
    input  logic              mem_ack_i,
    input  logic [15:0]       mem_rdata_i,
    output logic [15:0]       instruction_o,
    output logic              run_o,
    input  logic              done_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              halted_o,
    output logic              error_o,
    output logic [15:0]       instr_count_o
);

    localparam int              WD_W    = $clog2(DONE_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_NEXT,
        S_HALT
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [15:0]       instr_q;
    logic              run_q;
    logic              mem_req_q;
    logic              busy_q;
    logic              halted_q;
    logic              error_q;
    logic [15:0]       count_q;
    logic              stop_pending_q;
    logic [WD_W-1:0]   wd_q;
    logic              halt_d;

`ifdef BITTY_BRANCH_EN
    assign pc_d = branch_taken_i ? branch_target_i : pc_q + 1'b1;
`else
    logic unused_branch;
    assign unused_branch = ^{branch_taken_i, branch_target_i};
    assign pc_d          = pc_q + 1'b1;
`endif

    // Halt decision always uses the pc of the instruction that just retired.
    assign halt_d = (pc_q == LAST_ADDR) || stop_pending_q || stop_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            pc_q           <= '0;
            instr_q        <= '0;
            run_q          <= 1'b0;
            mem_req_q      <= 1'b0;
            busy_q         <= 1'b0;
            halted_q       <= 1'b0;
            error_q        <= 1'b0;
            count_q        <= '0;
            stop_pending_q <= 1'b0;
            wd_q           <= '0;
        end else begin
            if (busy_q && stop_i) begin
                stop_pending_q <= 1'b1;
            end
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start_i) begin
                        state_q        <= S_FETCH;
                        pc_q           <= '0;
                        count_q        <= '0;
                        error_q        <= 1'b0;
                        stop_pending_q <= 1'b0;
                        mem_req_q      <= 1'b1;
                        busy_q         <= 1'b1;
                        halted_q       <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (mem_ack_i) begin
                        instr_q   <= mem_rdata_i;
                        mem_req_q <= 1'b0;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    run_q   <= 1'b1;
                    wd_q    <= '0;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (done_i) begin
                        run_q   <= 1'b0;
                        count_q <= count_q + 16'd1;
                        state_q <= S_NEXT;
                    end else if (wd_q == WD_LAST) begin
                        // Control unit hung: abandon the instruction without retiring it.
                        error_q  <= 1'b1;
                        run_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (halt_d) begin
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        pc_q      <= pc_d;
                        mem_req_q <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_addr_o    = pc_q;
    assign pc_o          = pc_q;
    assign mem_req_o     = mem_req_q;
    assign instruction_o = instr_q;
    assign run_o         = run_q;
    assign busy_o        = busy_q;
    assign halted_o      = halted_q;
    assign error_o       = error_q;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_bitty_fetch_sequencer.sv
// tb/tb_bitty_fetch_sequencer.sv - randomized scoreboard bench for bitty_fetch_sequencer.
module tb_bitty_fetch_sequencer;

    localparam int        AW   = 8;
    localparam logic [7:0] LAST = 8'h0A;
    localparam int        TO   = 16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [7:0]  mem_addr_o;
    logic        mem_req_o;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instruction_o;
    logic        run_o;
    logic        done;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  pc_o;
    logic        busy_o;
    logic        halted_o;
    logic        error_o;
    logic [15:0] instr_count_o;

    bitty_fetch_sequencer #(
        .ADDR_W      (AW),
        .LAST_ADDR   (LAST),
        .DONE_TIMEOUT(TO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .stop_i         (stop),
        .mem_addr_o     (mem_addr_o),
        .mem_req_o      (mem_req_o),
        .mem_ack_i      (mem_ack),
        .mem_rdata_i    (mem_rdata),
        .instruction_o  (instruction_o),
        .run_o          (run_o),
        .done_i         (done),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .pc_o           (pc_o),
        .busy_o         (busy_o),
        .halted_o       (halted_o),
        .error_o        (error_o),
        .instr_count_o  (instr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
        logic [15:0] cnt;
    } issue_t;

    logic [7:0]  exp_addr_q[$];
    issue_t      exp_issue_q[$];
    int          exp_len_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    logic [15:0] mem[256];
    bit          br_t[64];
    logic [7:0]  br_a[64];
    int          stop_idx = -1;
    int          fault_idx = -1;
    int          run_gen = 0;
    int          cu_idx = 0;
    bit          mon_en = 1'b1;
    bit          force_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic miss(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
    endtask

    // Instruction memory: random 0-2 cycle ack latency, garbage rdata when not acking.
    int ack_wait = 0;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
            end else if (mem_req_o) begin
                if (ack_wait == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr_o];
                    ack_wait  = $urandom_range(0, 2);
                end else begin
                    ack_wait--;
                end
            end else begin
                mem_rdata = 16'($urandom);
            end
        end
    end

    // Control unit stand-in: done after a random delay, stop/withheld done on chosen instructions.
    int cu_gen = 0;
    int dcnt = 0;
    bit in_instr = 1'b0;
    bit fd_prev = 1'b0;
    initial begin
        done          = 1'b0;
        stop          = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        forever begin
            @(negedge clk);
            stop = 1'b0;
            if (cu_gen != run_gen) begin
                cu_gen = run_gen;
                cu_idx = 0;
            end
            if (done) begin
                done = 1'b0;
            end else if (force_done && !fd_prev) begin
                done = 1'b1;
            end else if (run_o) begin
                if (!in_instr) begin
                    in_instr = 1'b1;
                    if (cu_idx == stop_idx) stop = 1'b1;
                    if (cu_idx == fault_idx) begin
                        dcnt = -1;
                        exp_len_q.push_back(TO);
                    end else begin
                        dcnt = $urandom_range(0, 3);
                        exp_len_q.push_back(dcnt + 1);
                    end
                end
                if (dcnt == 0) begin
                    done          = 1'b1;
                    branch_taken  = br_t[cu_idx % 64];
                    branch_target = br_a[cu_idx % 64];
                    cu_idx++;
                    in_instr = 1'b0;
                end else if (dcnt > 0) begin
                    dcnt--;
                end
            end else begin
                in_instr = 1'b0;
                if (!busy_o) stop = 1'($urandom_range(0, 1));
            end
            fd_prev = force_done;
        end
    end

    // Monitor: pops the scoreboard on fetch start, issue, and run fall.
    logic        m_run_prev = 1'b0;
    logic        m_req_prev = 1'b0;
    int          m_run_len = 0;
    logic [15:0] m_held = '0;
    issue_t      m_e;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_req_o && !m_req_prev) begin
                    if (exp_addr_q.size() == 0) miss("fetch_extra");
                    else chk("fetch_addr", 32'(mem_addr_o), 32'(exp_addr_q.pop_front()));
                end
                if (run_o && !m_run_prev) begin
                    if (exp_issue_q.size() == 0) miss("issue_extra");
                    else begin
                        m_e = exp_issue_q.pop_front();
                        chk("issue_pc", 32'(pc_o), 32'(m_e.pc));
                        chk("issue_instr", 32'(instruction_o), 32'(m_e.instr));
                        chk("issue_count", 32'(instr_count_o), 32'(m_e.cnt));
                    end
                    m_held = instruction_o;
                end else if (run_o) begin
                    chk("instr_stable", 32'(instruction_o), 32'(m_held));
                end
                if (!run_o && m_run_prev) begin
                    if (exp_len_q.size() == 0) miss("run_fall_extra");
                    else chk("run_len", 32'(m_run_len), 32'(exp_len_q.pop_front()));
                end
            end
            if (run_o) m_run_len++;
            else m_run_len = 0;
            m_run_prev = run_o;
            m_req_prev = mem_req_o;
        end
    end

    task automatic run_program(input int s_idx, input int f_idx);
        int     pc;
        int     k;
        int     cycles;
        bit     exp_err;
        issue_t e;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 64; i++) begin
            br_t[i] = ($urandom_range(0, 3) == 0);
            br_a[i] = 8'($urandom);
        end
        stop_idx  = (s_idx < 0) ? 30 : s_idx;
        fault_idx = f_idx;
        pc = 0;
        k = 0;
        exp_err = 1'b0;
        forever begin
            exp_addr_q.push_back(8'(pc));
            e.pc = 8'(pc);
            e.instr = mem[pc];
            e.cnt = 16'(k);
            exp_issue_q.push_back(e);
            if (k == fault_idx) begin
                exp_err = 1'b1;
                break;
            end
            k++;
            if (pc == int'(LAST) || k - 1 == stop_idx) break;
`ifdef BITTY_BRANCH_EN
            pc = br_t[k - 1] ? int'(br_a[k - 1]) : (pc + 1) % 256;
`else
            pc = (pc + 1) % 256;
`endif
        end
        run_gen++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy_o), 32'd1);
        chk("start_pc", 32'(pc_o), 32'd0);
        chk("start_count", 32'(instr_count_o), 32'd0);
        chk("start_error", 32'(error_o), 32'd0);
        chk("start_halted", 32'(halted_o), 32'd0);
        cycles = 0;
        while (!halted_o && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 3000) miss("halt_wait_expired");
        repeat (2) @(negedge clk);
        chk("end_halted", 32'(halted_o), 32'd1);
        chk("end_busy", 32'(busy_o), 32'd0);
        chk("end_run", 32'(run_o), 32'd0);
        chk("end_mem_req", 32'(mem_req_o), 32'd0);
        chk("end_pc", 32'(pc_o), 32'(pc));
        chk("end_count", 32'(instr_count_o), 32'(k));
        chk("end_error", 32'(error_o), 32'(exp_err));
        chk("left_fetch", 32'(exp_addr_q.size()), 32'd0);
        chk("left_issue", 32'(exp_issue_q.size()), 32'd0);
        chk("left_runlen", 32'(exp_len_q.size()), 32'd0);
        exp_addr_q.delete();
        exp_issue_q.delete();
        exp_len_q.delete();
    endtask

    initial begin
        int cycles;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_run", 32'(run_o), 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_pc", 32'(pc_o), 32'd0);
        chk("rst_count", 32'(instr_count_o), 32'd0);
        chk("rst_instr", 32'(instruction_o), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy_o), 32'd0);

        run_program(-1, -1);
        run_program(1, -1);
        run_program(-1, 3);
        run_program(2, -1);
        run_program(int'(LAST), -1);
        for (int r = 0; r < 8; r++) begin
            run_program(($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : -1,
                        ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8) : -1);
        end

        mon_en    = 1'b0;
        stop_idx  = 30;
        fault_idx = -1;
        run_gen++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (!(run_o && cu_idx >= 2) && cycles < 500) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 500) miss("exec_wait_expired");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_run", 32'(run_o), 32'd0);
        chk("arst_mem_req", 32'(mem_req_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_pc", 32'(pc_o), 32'd0);
        chk("arst_count", 32'(instr_count_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        force_done = 1'b1;
        repeat (4) @(negedge clk);
        force_done = 1'b0;
        chk("post_busy", 32'(busy_o), 32'd0);
        chk("post_run", 32'(run_o), 32'd0);
        chk("post_count", 32'(instr_count_o), 32'd0);
        chk("post_halted", 32'(halted_o), 32'd0);
        chk("post_mem_req", 32'(mem_req_o), 32'd0);
        exp_addr_q.delete();
        exp_issue_q.delete();
        exp_len_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
